fetch_ifid_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS32 core.
- Holds the PC and drives the instruction-memory request.
- Computes redirect targets for branches and jumps from the instruction in ID.
- Consumes the hazard unit's hold (stall) and branch_has_hazard (redirect/flush) outputs.
- Presents instr_ID, pc4_ID and valid_ID to decode, and keeps saturating stall/flush performance counters.

---
 rtl/fetch_ifid_stage.sv | 108 ++++++++++
 tb/tb_fetch_ifid_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC register, instruction-memory request, branch/jump
// redirect and IF/ID pipeline register with saturating stall/flush counters.
`default_nettype none

module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             branch_has_hazard,
  input  logic [1:0]       jump,
  input  logic [31:0]      jr_value_ID,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_ID,
  output logic [31:0]      pc4_ID,
  output logic             valid_ID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;

  logic [31:0]      pc_q,    pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q,   pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [31:0] w_br_off;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign w_pc_plus4 = pc_q + 32'd4;

  always_comb begin
    w_target = {jr_value_ID[31:2], 2'b00};
    case (jump)
      JMP_NONE: w_target = pc4_q + w_br_off;
      JMP_J:    w_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
      default:  w_target = {jr_value_ID[31:2], 2'b00};
    endcase
  end

  // Hold beats redirect beats fetch; a redirect is only honoured when ID
  // holds a real instruction, so bubbles can never trigger one.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (hold) begin
      if (!(&stall_q)) stall_d = stall_q + 1'b1;
    end else if (branch_has_hazard && valid_q) begin
      pc_d    = w_target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (!(&flush_q)) flush_d = flush_q + 1'b1;
    end else if (imem_ready) begin
      pc_d    = w_pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = w_pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = ~hold;
  assign instr_ID  = instr_q;
  assign pc4_ID    = pc4_q;
  assign valid_ID  = valid_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed and randomized checks of fetch_ifid_stage
// against a rule-level reference model of the fetch/IF-ID behaviour.
`default_nettype none

module tb_fetch_ifid_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          CNT_W     = 16;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold = 1'b0;
  logic             branch_has_hazard = 1'b0;
  logic [1:0]       jump = 2'b00;
  logic [31:0]      jr_value_ID = 32'd0;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic             imem_ready = 1'b0;
  logic [31:0]      imem_rdata = 32'd0;
  logic [31:0]      instr_ID;
  logic [31:0]      pc4_ID;
  logic             valid_ID;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  fetch_ifid_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hold             (hold),
    .branch_has_hazard(branch_has_hazard),
    .jump             (jump),
    .jr_value_ID      (jr_value_ID),
    .imem_addr        (imem_addr),
    .imem_req         (imem_req),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .instr_ID         (instr_ID),
    .pc4_ID           (pc4_ID),
    .valid_ID         (valid_ID),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [31:0] model_target();
    int off;
    off = $signed(m_instr[15:0]);
    case (jump)
      2'b00:   return m_pc4 + 32'(off * 4);
      2'b01:   return (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      default: return jr_value_ID & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_step();
    if (hold) begin
      if (m_stall < CNT_MAX) m_stall++;
    end else if (branch_has_hazard && m_valid) begin
      m_pc = model_target(); m_instr = NOP_INSTR; m_valid = 1'b0;
      if (m_flush < CNT_MAX) m_flush++;
    end else if (imem_ready) begin
      m_pc = m_pc + 32'd4; m_instr = imem_rdata; m_pc4 = m_pc; m_valid = 1'b1;
    end else begin
      m_instr = NOP_INSTR; m_valid = 1'b0;
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check32({tag, ".imem_addr"}, imem_addr, m_pc);
    check32({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, ~hold});
    check32({tag, ".instr_ID"}, instr_ID, m_instr);
    check32({tag, ".pc4_ID"}, pc4_ID, m_pc4);
    check32({tag, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, m_valid});
    check32({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'(m_stall));
    check32({tag, ".flush_cnt"}, {16'd0, flush_cnt}, 32'(m_flush));
  endtask

  function automatic logic [31:0] tag_word(input logic [31:0] a);
    if (a == 32'h0000_00FC) return 32'h1000_FFFE;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic step(input string tag, input logic h, input logic b, input logic [1:0] j,
                      input logic [31:0] jr, input logic r, input logic [31:0] d);
    hold = h; branch_has_hazard = b; jump = j; jr_value_ID = jr;
    imem_ready = r; imem_rdata = d;
    cycle(tag);
  endtask

  task automatic fetch(input string tag);
    step(tag, 1'b0, 1'b0, 2'b00, 32'd0, 1'b1, tag_word(m_pc));
  endtask

  task automatic run_to(input string tag, input logic [31:0] target);
    for (int i = 0; i < 200 && m_pc != target; i++) fetch(tag);
    check32({tag, ".reached"}, imem_addr, target);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    check32("reset.pc4_const", pc4_ID, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch
    fetch("stream0");
    check32("stream0.instr", instr_ID, tag_word(32'd0));
    check32("stream0.pc4", pc4_ID, 32'd4);
    check32("stream0.addr", imem_addr, 32'd4);
    run_to("stream", 32'h14);

    // Three-cycle hold
    for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 32'hDEAD_BEEF);
    check32("hold.stall3", {16'd0, stall_cnt}, 32'd3);
    check32("hold.addr_frozen", imem_addr, 32'h14);
    fetch("resume");
    check32("resume.instr", instr_ID, tag_word(32'h14));

    // Memory not ready at PC=0x40, redirect request on a bubble ignored
    run_to("to40", 32'h40);
    step("bubble1", 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 32'hBAD0_0001);
    step("bubble2", 1'b0, 1'b1, 2'b10, 32'h0000_2000, 1'b0, 32'hBAD0_0002);
    check32("bubble.addr", imem_addr, 32'h40);
    check32("bubble.flush0", {16'd0, flush_cnt}, 32'd0);

    // Backward branch from pc4_ID=0x100, imm=-2
    run_to("to_fc", 32'hFC);
    fetch("br_fetch");
    check32("br.pc4", pc4_ID, 32'h100);
    step("br_hold", 1'b1, 1'b1, 2'b00, 32'd0, 1'b1, 32'd0);
    check32("br_hold.no_redirect", {16'd0, flush_cnt}, 32'd0);
    step("br_take", 1'b0, 1'b1, 2'b00, 32'd0, 1'b1, 32'hBAD0_0003);
    check32("br.target", imem_addr, 32'h0F8);
    check32("br.flush1", {16'd0, flush_cnt}, 32'd1);

    // J target in the upper region
    step("jr_to_8000", 1'b0, 1'b0, 2'b00, 32'd0, 1'b1, tag_word(m_pc));
    step("jr_redir", 1'b0, 1'b1, 2'b10, 32'h8000_000F, 1'b1, 32'd0);
    step("j_fetch", 1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 32'h0BFF_FFFF);
    check32("j.pc4", pc4_ID, 32'h8000_0010);
    step("j_redir", 1'b0, 1'b1, 2'b01, 32'd0, 1'b1, 32'd0);
    check32("j.target", imem_addr, 32'h8FFF_FFFC);

    // JR with misaligned register value
    fetch("jr_fetch");
    step("jr_redir2", 1'b0, 1'b1, 2'b10, 32'h0000_1237, 1'b1, 32'd0);
    check32("jr.target", imem_addr, 32'h0000_1234);

    // PC wrap at the top of the address space
    fetch("wrap_fetch");
    step("jalr_top", 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 1'b1, 32'd0);
    check32("wrap.pre", imem_addr, 32'hFFFF_FFFC);
    fetch("wrap");
    check32("wrap.pc0", imem_addr, 32'h0000_0000);
    check32("wrap.pc4", pc4_ID, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(99) < 15), ($urandom_range(99) < 30),
           2'($urandom_range(3)), $urandom, ($urandom_range(99) < 75), $urandom);
    end

    // Stall counter saturation
    for (int i = 0; i < (1 << 16) + 5; i++) step("sat", 1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 32'd0);
    check32("sat.stall_max", {16'd0, stall_cnt}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of a stall
    @(posedge clk);
    model_step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check32("async_rst.stall0", {16'd0, stall_cnt}, 32'd0);
    check32("async_rst.valid0", {31'd0, valid_ID}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    #1;
    check32("post_rst.first_fetch", imem_addr, RESET_PC);
    fetch("post_rst");
    check32("post_rst.instr", instr_ID, tag_word(RESET_PC));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
